// File: rtl/face_box_frame_ctrl_pkg.sv
// face_box_pkg: shared geometry, FSM encoding and box layout for the face box frame controller
package face_box_pkg;
  localparam int W = 12;
  localparam int IMG_H = 640;
  localparam int IMG_V = 480;
  localparam int MIN_SIZE = 16;
  localparam int ALPHA_SH = 2;
  localparam int MISS_MAX = 4;
  localparam int BOX_W = 4 * W;
  typedef enum logic [2:0] {IDLE, WAIT_FRAME, IN_FRAME, CHECK, FILTER, PUBLISH} state_t;
  // x_min occupies the low W bits so coordinate i sits at [i*W +: W]
  typedef struct packed {
    logic [W-1:0] y_max;
    logic [W-1:0] y_min;
    logic [W-1:0] x_max;
    logic [W-1:0] x_min;
  } box_t;
endpackage

// File: rtl/face_box_frame_ctrl_if.sv
// face_box_frame_ctrl_if: frame/box signals between the processor side and the tracker
interface face_box_frame_ctrl_if;
  import face_box_pkg::*;
  logic enable;
  logic vsync_in;
  logic [W-1:0] raw_x_min, raw_x_max, raw_y_min, raw_y_max;
  logic [W-1:0] trk_x_min, trk_x_max, trk_y_min, trk_y_max;
  logic trk_valid;
  logic frame_done;
  logic raw_ok;
  logic [2:0] miss_cnt;
  logic [15:0] frame_cnt;
  modport master (
    output enable, vsync_in, raw_x_min, raw_x_max, raw_y_min, raw_y_max,
    input trk_x_min, trk_x_max, trk_y_min, trk_y_max, trk_valid, frame_done, raw_ok, miss_cnt, frame_cnt
  );
  modport slave (
    input enable, vsync_in, raw_x_min, raw_x_max, raw_y_min, raw_y_max,
    output trk_x_min, trk_x_max, trk_y_min, trk_y_max, trk_valid, frame_done, raw_ok, miss_cnt, frame_cnt
  );
endinterface

// File: rtl/face_box_frame_ctrl_iir.sv
// box_iir_step: one-coordinate IIR step, cur moves toward tgt by (tgt-cur)>>>ALPHA_SH, or loads tgt
module box_iir_step #(
  parameter int W = 12,
  parameter int ALPHA_SH = 2
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] tgt,
  input  logic         load,
  output logic [W-1:0] nxt
);
  logic signed [W:0] d;
  logic signed [W:0] s;
  always_comb begin
    d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    s = d >>> ALPHA_SH;
    nxt = load ? tgt : cur + s[W-1:0];
  end
endmodule

// File: rtl/face_box_frame_ctrl.sv
// face_box_frame_ctrl: samples the face box at vsync fall, validates, smooths and publishes it per frame
module face_box_frame_ctrl
  import face_box_pkg::*;
(
  input logic clk,
  input logic rst,
  face_box_frame_ctrl_if.slave bus
);
  localparam logic [W-1:0] H_LIM = W'(IMG_H);
  localparam logic [W-1:0] V_LIM = W'(IMG_V);
  localparam logic [W-1:0] MIN_W = W'(MIN_SIZE);
  localparam logic [2:0] MISS_M = 3'(MISS_MAX);
  state_t state;
  box_t cap, trk, nxt;
  logic vsync_d, pending_rise, ok, box_ok;
  logic trk_valid, frame_done, raw_ok;
  logic [2:0] miss_cnt, miss_n;
  logic [15:0] frame_cnt;
  logic rise, fall;
  assign rise = ~vsync_d & bus.vsync_in;
  assign fall = vsync_d & ~bus.vsync_in;
  always_comb begin
    box_ok = (cap.x_min < cap.x_max) & (cap.y_min < cap.y_max)
           & ((cap.x_max - cap.x_min) >= MIN_W) & ((cap.y_max - cap.y_min) >= MIN_W)
           & (cap.x_max < H_LIM) & (cap.y_max < V_LIM);
    miss_n = (miss_cnt >= MISS_M) ? MISS_M : miss_cnt + 3'd1;
  end
  for (genvar i = 0; i < 4; i++) begin : g_iir
    box_iir_step #(.W(W), .ALPHA_SH(ALPHA_SH)) u_step (
      .cur (trk[i*W +: W]),
      .tgt (cap[i*W +: W]),
      .load(~trk_valid),
      .nxt (nxt[i*W +: W])
    );
  end
  // Outputs are registered on the FILTER->PUBLISH edge so frame_done is visible during PUBLISH
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vsync_d <= 1'b0;
      pending_rise <= 1'b0;
      ok <= 1'b0;
      cap <= '0;
      trk <= '0;
      trk_valid <= 1'b0;
      frame_done <= 1'b0;
      raw_ok <= 1'b0;
      miss_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      vsync_d <= bus.vsync_in;
      frame_done <= 1'b0;
      if (!bus.enable) begin
        state <= IDLE;
        trk_valid <= 1'b0;
        pending_rise <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= WAIT_FRAME;
          WAIT_FRAME: if (rise) state <= IN_FRAME;
          IN_FRAME: if (fall) begin
            cap <= '{bus.raw_y_max, bus.raw_y_min, bus.raw_x_max, bus.raw_x_min};
            state <= CHECK;
          end
          CHECK: begin
            ok <= box_ok;
            pending_rise <= pending_rise | rise;
            state <= FILTER;
          end
          FILTER: begin
            pending_rise <= pending_rise | rise;
            frame_done <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
            raw_ok <= ok;
            if (ok) begin
              trk <= nxt;
              trk_valid <= 1'b1;
              miss_cnt <= '0;
            end else begin
              miss_cnt <= miss_n;
              if (miss_n == MISS_M) trk_valid <= 1'b0;
            end
            state <= PUBLISH;
          end
          PUBLISH: begin
            state <= (pending_rise | rise) ? IN_FRAME : WAIT_FRAME;
            pending_rise <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
  assign bus.trk_x_min = trk.x_min;
  assign bus.trk_x_max = trk.x_max;
  assign bus.trk_y_min = trk.y_min;
  assign bus.trk_y_max = trk.y_max;
  assign bus.trk_valid = trk_valid;
  assign bus.frame_done = frame_done;
  assign bus.raw_ok = raw_ok;
  assign bus.miss_cnt = miss_cnt;
  assign bus.frame_cnt = frame_cnt;
endmodule

// File: tb/tb_face_box_frame_ctrl.sv
// tb_face_box_frame_ctrl: directed plus random frames checked against a per-frame arithmetic model
module tb_face_box_frame_ctrl;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int m_trk[4];
  int m_valid, m_miss, m_cnt, m_rawok;
  face_box_frame_ctrl_if bus();
  face_box_frame_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(negedge clk) if (bus.frame_done === 1'b1) n_done++;
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic int fdiv4(input int d);
    return (d >= 0) ? d / 4 : -((-d + 3) / 4);
  endfunction
  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_trk[i] = 0;
    m_valid = 0; m_miss = 0; m_cnt = 0; m_rawok = 0;
  endfunction
  function automatic void model_frame(input int xa, input int xb, input int ya, input int yb);
    int c[4];
    bit ok;
    c = '{xa, xb, ya, yb};
    ok = xa < xb && ya < yb && xb - xa >= 16 && yb - ya >= 16 && xb < 640 && yb < 480;
    if (ok) begin
      for (int i = 0; i < 4; i++) m_trk[i] = m_valid ? m_trk[i] + fdiv4(c[i] - m_trk[i]) : c[i];
      m_valid = 1; m_miss = 0; m_rawok = 1;
    end else begin
      m_rawok = 0;
      m_miss = (m_miss + 1 > 4) ? 4 : m_miss + 1;
      if (m_miss == 4) m_valid = 0;
    end
    m_cnt = (m_cnt + 1) % 65536;
  endfunction
  task automatic check_all(input string tag);
    chk({tag, "_x_min"}, 32'(bus.trk_x_min), 32'(m_trk[0]));
    chk({tag, "_x_max"}, 32'(bus.trk_x_max), 32'(m_trk[1]));
    chk({tag, "_y_min"}, 32'(bus.trk_y_min), 32'(m_trk[2]));
    chk({tag, "_y_max"}, 32'(bus.trk_y_max), 32'(m_trk[3]));
    chk({tag, "_valid"}, 32'(bus.trk_valid), 32'(m_valid));
    chk({tag, "_raw_ok"}, 32'(bus.raw_ok), 32'(m_rawok));
    chk({tag, "_miss"}, 32'(bus.miss_cnt), 32'(m_miss));
    chk({tag, "_fcnt"}, 32'(bus.frame_cnt), 32'(m_cnt));
  endtask
  task automatic run_frame(input string tag, input int xa, input int xb, input int ya, input int yb, input bit btb);
    int d0;
    if (bus.vsync_in == 1'b0) begin
      step();
      bus.vsync_in = 1'b1;
    end
    repeat (2) step();
    bus.raw_x_min = 12'($urandom); bus.raw_x_max = 12'($urandom);
    bus.raw_y_min = 12'($urandom); bus.raw_y_max = 12'($urandom);
    step();
    bus.raw_x_min = 12'(xa); bus.raw_x_max = 12'(xb);
    bus.raw_y_min = 12'(ya); bus.raw_y_max = 12'(yb);
    repeat (2) step();
    step();
    bus.vsync_in = 1'b0;
    d0 = n_done;
    step();
    if (btb) bus.vsync_in = 1'b1;
    step();
    chk({tag, "_done_early"}, 32'(bus.frame_done), 32'd0);
    step();
    model_frame(xa, xb, ya, yb);
    chk({tag, "_done_lat"}, 32'(bus.frame_done), 32'd1);
    check_all(tag);
    step();
    chk({tag, "_done_pulse"}, 32'(n_done - d0), 32'd1);
  endtask
  task automatic quiet(input string tag, input int cycles);
    int d0;
    d0 = n_done;
    repeat (cycles) step();
    chk({tag, "_no_done"}, 32'(n_done - d0), 32'd0);
  endtask
  initial begin
    int xa, xb, ya, yb;
    rst = 1'b1;
    bus.enable = 1'b0; bus.vsync_in = 1'b0;
    bus.raw_x_min = '0; bus.raw_x_max = '0; bus.raw_y_min = '0; bus.raw_y_max = '0;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    step();
    check_all("reset");
    chk("reset_done", 32'(bus.frame_done), 32'd0);
    bus.enable = 1'b1;
    step();
    run_frame("t1", 100, 200, 50, 150, 1'b0);
    chk("t1_lock_x_min", 32'(bus.trk_x_min), 32'd100);
    chk("t1_fcnt", 32'(bus.frame_cnt), 32'd1);
    run_frame("t2a", 140, 200, 50, 150, 1'b0);
    chk("t2_first_x_min", 32'(bus.trk_x_min), 32'd110);
    run_frame("t2b", 140, 200, 50, 150, 1'b0);
    chk("t2_second_x_min", 32'(bus.trk_x_min), 32'd117);
    run_frame("t3_minmax", 200, 100, 50, 150, 1'b0);
    run_frame("t3_narrow", 100, 110, 50, 150, 1'b0);
    run_frame("t3_xedge", 100, 640, 50, 150, 1'b0);
    chk("t3_three_miss", 32'(bus.miss_cnt), 32'd3);
    chk("t3_still_valid", 32'(bus.trk_valid), 32'd1);
    run_frame("t3_yedge", 100, 200, 50, 480, 1'b0);
    chk("t3_four_miss", 32'(bus.miss_cnt), 32'd4);
    chk("t3_dropped", 32'(bus.trk_valid), 32'd0);
    run_frame("t3_miss5", 0, 0, 0, 0, 1'b0);
    chk("t3_miss_sat", 32'(bus.miss_cnt), 32'd4);
    run_frame("t3_relock", 300, 400, 200, 300, 1'b0);
    chk("t3_relock_x_min", 32'(bus.trk_x_min), 32'd300);
    run_frame("edge_ok", 623, 639, 463, 479, 1'b0);
    bus.enable = 1'b0;
    step();
    m_valid = 0;
    chk("t4_disable_valid", 32'(bus.trk_valid), 32'd0);
    bus.vsync_in = 1'b1;
    repeat (2) step();
    bus.enable = 1'b1;
    repeat (3) step();
    bus.raw_x_min = 12'd10; bus.raw_x_max = 12'd90; bus.raw_y_min = 12'd10; bus.raw_y_max = 12'd90;
    bus.vsync_in = 1'b0;
    quiet("t4_partial", 8);
    run_frame("t4_full", 20, 120, 30, 130, 1'b0);
    chk("t4_direct_load", 32'(bus.trk_x_min), 32'd20);
    step();
    bus.vsync_in = 1'b1;
    repeat (3) step();
    bus.enable = 1'b0;
    step();
    bus.vsync_in = 1'b0;
    m_valid = 0;
    quiet("t5_en_drop", 8);
    check_all("t5_en_drop");
    bus.enable = 1'b1;
    repeat (2) step();
    run_frame("t5_reenable", 200, 300, 100, 200, 1'b0);
    step();
    bus.vsync_in = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    bus.vsync_in = 1'b0;
    step();
    rst = 1'b0;
    model_reset();
    quiet("t5_rst", 8);
    check_all("t5_rst");
    run_frame("t5_after_rst", 50, 150, 60, 160, 1'b0);
    run_frame("t6_a", 80, 180, 70, 170, 1'b1);
    run_frame("t6_b", 120, 220, 90, 190, 1'b1);
    run_frame("t6_c", 160, 260, 110, 210, 1'b0);
    for (int k = 0; k < 24; k++) begin
      xa = $urandom_range(0, 560); xb = xa + $urandom_range(5, 120);
      ya = $urandom_range(0, 400); yb = ya + $urandom_range(5, 120);
      if ($urandom_range(0, 7) == 0) begin
        int t;
        t = xa; xa = xb; xb = t;
      end
      run_frame("rnd", xa, xb, ya, yb, 1'($urandom_range(0, 1)));
    end
    bus.vsync_in = 1'b0;
    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
